// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared seven-segment pattern table and cathode bit map
package seven_seg_pkg;

    // Segment lines are driven low to light a segment.
    localparam logic SEG_ACTIVE = 1'b0;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A_HEX = 7'h08;
    localparam logic [6:0] SEG_B_HEX = 7'h03;
    localparam logic [6:0] SEG_C_HEX = 7'h46;
    localparam logic [6:0] SEG_D_HEX = 7'h21;
    localparam logic [6:0] SEG_E_HEX = 7'h06;
    localparam logic [6:0] SEG_F_HEX = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - inverse of the segment table: pattern to hex nibble
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_invalid
);

    always_comb begin
        o_nibble  = 4'h0;
        o_invalid = 1'b0;
        case (i_pattern)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
            SEG_A_HEX: o_nibble = 4'hA;
            SEG_B_HEX: o_nibble = 4'hB;
            SEG_C_HEX: o_nibble = 4'hC;
            SEG_D_HEX: o_nibble = 4'hD;
            SEG_E_HEX: o_nibble = 4'hE;
            SEG_F_HEX: o_nibble = 4'hF;
            default:   o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// rtl/seven_seg_scan_capture.sv - samples a multiplexed display bus and rebuilds whole frames
module seven_seg_scan_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic [7:0]              cathode_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   invalid_out,
    output logic                    frame_valid,
    output logic                    scan_err
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0]   r_an, r_an_prev;
    logic [7:0]              r_cat, r_cat_prev;
    logic [7:0]              r_cnt;
    logic                    r_acc;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic [4*NUM_DIGITS-1:0] r_sh_dig, r_digits;
    logic [NUM_DIGITS-1:0]   r_sh_dp, r_sh_inv, r_dp, r_inv;
    logic                    r_fv, r_serr;

    logic [NUM_DIGITS-1:0]   w_low;
    logic                    w_one_hot, w_multi, w_same, w_acc_held, w_accept, w_acc_next;
    logic [7:0]              w_cnt;
    logic [3:0]              w_nib;
    logic                    w_inv, w_dp, w_frame_done;
    logic [4*NUM_DIGITS-1:0] w_sh_dig;
    logic [NUM_DIGITS-1:0]   w_sh_dp, w_sh_inv, w_seen_next;

    seg_pattern_decode u_decode (
        .i_pattern (r_cat[6:0]),
        .o_nibble  (w_nib),
        .o_invalid (w_inv)
    );

    assign w_low     = ~r_an;
    assign w_one_hot = ($countones(w_low) == 1);
    assign w_multi   = ($countones(w_low) > 1);
    assign w_same    = (r_an == r_an_prev) && (r_cat == r_cat_prev);
    assign w_dp      = (r_cat[SEG_DP] == SEG_ACTIVE);

    // w_cnt is the run length of the sample currently held, including itself.
    always_comb begin
        w_cnt = 8'd0;
        if (w_one_hot) begin
            if (!w_same)
                w_cnt = 8'd1;
            else if (r_cnt == STABLE_C)
                w_cnt = STABLE_C;
            else
                w_cnt = r_cnt + 8'd1;
        end
    end

    assign w_acc_held = r_acc && w_same;
    assign w_accept   = w_one_hot && (w_cnt == STABLE_C) && !w_acc_held;
    assign w_acc_next = w_one_hot && (w_acc_held || w_accept);

    // The accepting digit is merged here so a completing frame carries it without lag.
    always_comb begin
        w_sh_dig    = r_sh_dig;
        w_sh_dp     = r_sh_dp;
        w_sh_inv    = r_sh_inv;
        w_seen_next = r_seen;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_accept && w_low[k]) begin
                w_sh_dig[4*k +: 4] = w_nib;
                w_sh_dp[k]         = w_dp;
                w_sh_inv[k]        = w_inv;
                w_seen_next[k]     = 1'b1;
            end
        end
    end

    assign w_frame_done = &w_seen_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an       <= '1;
            r_an_prev  <= '1;
            r_cat      <= '1;
            r_cat_prev <= '1;
            r_cnt      <= 8'd0;
            r_acc      <= 1'b0;
            r_seen     <= '0;
            r_sh_dig   <= '0;
            r_sh_dp    <= '0;
            r_sh_inv   <= '0;
            r_digits   <= '0;
            r_dp       <= '0;
            r_inv      <= '0;
            r_fv       <= 1'b0;
            r_serr     <= 1'b0;
        end else begin
            r_an       <= an_in;
            r_cat      <= cathode_in;
            r_an_prev  <= r_an;
            r_cat_prev <= r_cat;
            r_cnt      <= w_cnt;
            r_acc      <= w_acc_next;
            r_sh_dig   <= w_sh_dig;
            r_sh_dp    <= w_sh_dp;
            r_sh_inv   <= w_sh_inv;
            r_fv       <= w_frame_done;
            r_serr     <= w_multi;
            if (w_frame_done) begin
                r_seen   <= '0;
                r_digits <= w_sh_dig;
                r_dp     <= w_sh_dp;
                r_inv    <= w_sh_inv;
            end else begin
                r_seen   <= w_seen_next;
            end
        end
    end

    assign digits_out  = r_digits;
    assign dp_out      = r_dp;
    assign invalid_out = r_inv;
    assign frame_valid = r_fv;
    assign scan_err    = r_serr;

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// tb/tb_seven_seg_scan_capture.sv - directed bench with a frame-level reference model
module tb_seven_seg_scan_capture;

    localparam int N  = 8;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    an_in = '1;
    logic [7:0]    cathode_in = '1;
    logic [31:0]   digits_out;
    logic [7:0]    dp_out;
    logic [7:0]    invalid_out;
    logic          frame_valid;
    logic          scan_err;

    always #5 clk = ~clk;

    seven_seg_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .an_in       (an_in),
        .cathode_in  (cathode_in),
        .digits_out  (digits_out),
        .dp_out      (dp_out),
        .invalid_out (invalid_out),
        .frame_valid (frame_valid),
        .scan_err    (scan_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    localparam logic [6:0] TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference: a digit is taken once its sample has been held for exactly SC cycles.
    logic [31:0] e_dig = '0, s_dig = '0;
    logic [7:0]  e_dp = '0, e_inv = '0, s_dp = '0, s_inv = '0, seen = '0;
    logic        e_fv = 1'b0, e_se = 1'b0;
    logic [7:0]  m_an = '1, m_cat = '1, m_pan = '1, m_pcat = '1;
    int          m_run = 0;

    always @(posedge clk) begin : model
        int  idx;
        int  nib;
        logic inv;
        if (rst) begin
            e_dig = '0; e_dp = '0; e_inv = '0; e_fv = 1'b0; e_se = 1'b0;
            s_dig = '0; s_dp = '0; s_inv = '0; seen = '0;
            m_an = '1; m_cat = '1; m_pan = '1; m_pcat = '1; m_run = 0;
        end else begin
            if (m_an == m_pan && m_cat == m_pcat) m_run++;
            else m_run = 1;
            e_se = ($countones(~m_an) > 1);
            e_fv = 1'b0;
            if ($countones(~m_an) == 1 && m_run == SC) begin
                idx = 0;
                for (int k = 0; k < N; k++) if (!m_an[k]) idx = k;
                nib = 0; inv = 1'b1;
                for (int v = 0; v < 16; v++) if (m_cat[6:0] == TAB[v]) begin nib = v; inv = 1'b0; end
                s_dig[4*idx +: 4] = 4'(nib);
                s_dp[idx]  = ~m_cat[7];
                s_inv[idx] = inv;
                seen[idx]  = 1'b1;
                if (seen == 8'hFF) begin
                    e_dig = s_dig; e_dp = s_dp; e_inv = s_inv; e_fv = 1'b1; seen = '0;
                end
            end
            m_pan = m_an; m_pcat = m_cat;
            m_an = an_in; m_cat = cathode_in;
        end
    end

    always @(negedge clk) begin
        check("digits_out",  digits_out,  e_dig);
        check("dp_out",      32'(dp_out), 32'(e_dp));
        check("invalid_out", 32'(invalid_out), 32'(e_inv));
        check("frame_valid", 32'(frame_valid), 32'(e_fv));
        check("scan_err",    32'(scan_err), 32'(e_se));
    end

    int n_frames = 0, n_serr = 0, cur_digit = -1, last_dig = -1;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin n_frames++; last_dig = cur_digit; end
        if (scan_err === 1'b1) n_serr++;
    end

    logic [7:0] pat [8];
    localparam logic [7:0] BASE [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    localparam logic [7:0] HIGH [8] = '{8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic show(input int d, input logic [7:0] c, input int dwell);
        an_in = ~(8'd1 << d);
        cathode_in = c;
        cur_digit = d;
        repeat (dwell) @(negedge clk);
    endtask

    task automatic scan(input int lo, input int hi);
        for (int d = lo; d <= hi; d++) show(d, pat[d], 10);
    endtask

    task automatic do_reset();
        rst = 1'b1; an_in = '1; cathode_in = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int f0;
        int s0;
        int lat;
        repeat (2) @(negedge clk);
        check("reset digits", digits_out, 32'h0);
        check("reset frame_valid", 32'(frame_valid), 32'h0);
        rst = 1'b0;

        pat = BASE; f0 = n_frames;
        scan(0, 7);
        check("t1 frames", n_frames, f0 + 1);
        check("t1 frame digit", last_dig, 7);
        check("t1 digits", digits_out, 32'h76543210);
        check("t1 invalid", 32'(invalid_out), 32'h0);
        check("t1 dp", 32'(dp_out), 32'h0);

        do_reset();
        for (int i = 0; i < 8; i++) pat[i] = 8'hC0;
        pat[2] = 8'h24; f0 = n_frames;
        scan(0, 6);
        an_in = ~8'h80; cathode_in = 8'hC0; cur_digit = 7; lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (frame_valid === 1'b1 && lat < 0) lat = c;
        end
        check("t2 latency", lat, 5);
        check("t2 digits", digits_out, 32'h00000200);
        check("t2 dp", 32'(dp_out), 32'h04);
        check("t2 frames", n_frames, f0 + 1);

        do_reset();
        pat = BASE; f0 = n_frames;
        scan(0, 4);
        show(5, pat[5], 3);
        scan(6, 7);
        check("t3 no frame", n_frames, f0);
        check("t3 held digits", digits_out, 32'h0);
        scan(0, 7);
        check("t3 frames", n_frames, f0 + 1);
        check("t3 frame digit", last_dig, 5);
        check("t3 digits", digits_out, 32'h76543210);

        do_reset();
        f0 = n_frames; s0 = n_serr;
        scan(0, 3);
        show(4, pat[4], 3);
        an_in = 8'b11110011;
        @(negedge clk);
        show(4, pat[4], 10);
        scan(5, 7);
        check("t4 scan_err pulses", n_serr, s0 + 1);
        check("t4 frames", n_frames, f0 + 1);
        check("t4 frame digit", last_dig, 7);
        check("t4 digits", digits_out, 32'h76543210);

        do_reset();
        pat[4] = 8'hFF; pat[6] = 8'h55;
        scan(0, 7);
        check("t5 invalid", 32'(invalid_out), 32'h50);
        check("t5 digits", digits_out, 32'h70503210);
        check("t5 dp", 32'(dp_out), 32'h40);

        pat = HIGH; f0 = n_frames;
        scan(0, 4);
        rst = 1'b1; an_in = '1; cathode_in = '1;
        repeat (2) @(negedge clk);
        check("t6 reset digits", digits_out, 32'h0);
        check("t6 reset invalid", 32'(invalid_out), 32'h0);
        check("t6 reset dp", 32'(dp_out), 32'h0);
        rst = 1'b0;
        scan(5, 7);
        check("t6 no frame", n_frames, f0);
        scan(0, 4);
        check("t6 frames", n_frames, f0 + 1);
        check("t6 frame digit", last_dig, 4);
        check("t6 digits", digits_out, 32'hFEDCBA98);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
